wb_sram_arbiter_2m: RTL and testbench

Two-master Wishbone arbiter and sequencer for the sky130 OpenRAM 1 kB macro (32x256, port 0 RW). It accepts classic single-cycle-strobe Wishbone requests from master A (management SoC) and master B (user-area logic), grants one at a time, and drives the macro's port 0 with registered controls. The macro's read-only port 1 is tied off outside this block.

---
 rtl/wb_sram_arbiter_2m_if.sv | 22 ++
 rtl/wb_sram_arbiter_2m.sv | 119 +++++++++++
 tb/tb_wb_sram_arbiter_2m.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_arbiter_2m_if.sv
// Classic single-strobe Wishbone port, one instance per master of wb_sram_arbiter_2m.
// The master modport drives the request; the slave modport returns ack and read data.
interface wb_sram_arbiter_2m_if;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;

  modport master (
    output stb, cyc, we, sel, adr, wdat,
    input  ack, rdat
  );

  modport slave (
    input  stb, cyc, we, sel, adr, wdat,
    output ack, rdat
  );
endinterface

// File: rtl/wb_sram_arbiter_2m.sv
// Two-master Wishbone arbiter/sequencer for a 32x256 OpenRAM macro, port 0.
// Macro WB_SRAM_ARB_RR_EN selects round-robin arbitration; default is fixed priority (A wins).
module wb_sram_arbiter_2m #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hffff_fc00
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  wb_sram_arbiter_2m_if.slave        wbs_a,
  wb_sram_arbiter_2m_if.slave        wbs_b,
  output logic                       sram_csb0_o,
  output logic                       sram_web0_o,
  output logic [3:0]                 sram_wmask0_o,
  output logic [7:0]                 sram_addr0_o,
  output logic [31:0]                sram_din0_o,
  input  logic [31:0]                sram_dout0_i
);

  typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_grant;  // 0: master A, 1: master B
  logic        r_csb;
  logic        r_web;
  logic [3:0]  r_wmask;
  logic [7:0]  r_addr;
  logic [31:0] r_din;

  logic        w_req_a;
  logic        w_req_b;
  logic        w_winner;
  logic        w_load;
  logic        w_we;
  logic [3:0]  w_sel;
  logic [31:0] w_adr;
  logic [31:0] w_dat;
  logic        w_resp;

  assign w_req_a = wbs_a.stb & wbs_a.cyc & ((wbs_a.adr & ADDR_MASK) == BASE_ADDR);
  assign w_req_b = wbs_b.stb & wbs_b.cyc & ((wbs_b.adr & ADDR_MASK) == BASE_ADDR);

`ifdef WB_SRAM_ARB_RR_EN
  logic r_last_grant;

  // On a tie the master not served last wins; reset to B so A takes the first tie.
  assign w_winner = (w_req_a & w_req_b) ? ~r_last_grant : w_req_b;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_last_grant <= 1'b1;
    end else if (w_load) begin
      r_last_grant <= w_winner;
    end
  end
`else
  assign w_winner = ~w_req_a;
`endif

  assign w_we  = w_winner ? wbs_b.we   : wbs_a.we;
  assign w_sel = w_winner ? wbs_b.sel  : wbs_a.sel;
  assign w_adr = w_winner ? wbs_b.adr  : wbs_a.adr;
  assign w_dat = w_winner ? wbs_b.wdat : wbs_a.wdat;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req_a | w_req_b) begin
          w_load      = 1'b1;
          w_state_nxt = StCmd;
        end
      end
      StCmd:   w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // csb0 is low only during CMD; the other controls hold until the next grant.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= StIdle;
      r_grant <= 1'b0;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= 4'h0;
      r_addr  <= 8'h00;
      r_din   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_grant <= w_winner;
        r_csb   <= 1'b0;
        r_web   <= ~w_we;
        r_wmask <= w_sel;
        r_addr  <= w_adr[9:2];
        r_din   <= w_dat;
      end else if (r_state == StCmd) begin
        r_csb <= 1'b1;
      end
    end
  end

  assign sram_csb0_o   = r_csb;
  assign sram_web0_o   = r_web;
  assign sram_wmask0_o = r_wmask;
  assign sram_addr0_o  = r_addr;
  assign sram_din0_o   = r_din;

  // A master that dropped cyc/stb before RESP gets no ack; the access itself still ran.
  assign w_resp     = (r_state == StResp);
  assign wbs_a.ack  = w_resp & ~r_grant & wbs_a.cyc & wbs_a.stb;
  assign wbs_b.ack  = w_resp &  r_grant & wbs_b.cyc & wbs_b.stb;
  assign wbs_a.rdat = (wbs_a.ack & r_web) ? sram_dout0_i : 32'h0;
  assign wbs_b.rdat = (wbs_b.ack & r_web) ? sram_dout0_i : 32'h0;

endmodule

// File: tb/tb_wb_sram_arbiter_2m.sv
// Scoreboard bench for wb_sram_arbiter_2m: per-master expected-response queues fed at issue
// time from a word-level memory model, drained by a monitor on every ack.
module tb_wb_sram_arbiter_2m;
  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;

  wb_sram_arbiter_2m_if a_if();
  wb_sram_arbiter_2m_if b_if();

  wb_sram_arbiter_2m dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .wbs_a         (a_if),
    .wbs_b         (b_if),
    .sram_csb0_o   (sram_csb0),
    .sram_web0_o   (sram_web0),
    .sram_wmask0_o (sram_wmask0),
    .sram_addr0_o  (sram_addr0),
    .sram_din0_o   (sram_din0),
    .sram_dout0_i  (sram_dout0)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the macro: samples controls at the clock edge ending CMD.
  logic [31:0] sram_mem [256];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int i = 0; i < 4; i++)
          if (sram_wmask0[i]) sram_mem[sram_addr0][8*i +: 8] <= sram_din0[8*i +: 8];
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
  end

  logic [31:0] model_mem [256];
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  int          ack_cyc_q[$];
  bit          ack_who_q[$];
  bit          log_en = 1'b0;
  int          cyc_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (a_if.ack || b_if.ack)) begin
      check("dual_ack", {31'b0, a_if.ack & b_if.ack}, 32'h0);
      if (a_if.ack) begin
        if (exp_a_q.size() == 0) check("a_spurious_ack", {31'b0, a_if.ack}, 32'h0);
        else check("a_rdata", a_if.rdat, exp_a_q.pop_front());
        check("b_rdata_idle", b_if.rdat, 32'h0);
      end
      if (b_if.ack) begin
        if (exp_b_q.size() == 0) check("b_spurious_ack", {31'b0, b_if.ack}, 32'h0);
        else check("b_rdata", b_if.rdat, exp_b_q.pop_front());
        check("a_rdata_idle", a_if.rdat, 32'h0);
      end
      if (log_en) begin
        ack_cyc_q.push_back(cyc_cnt);
        ack_who_q.push_back(b_if.ack);
      end
    end
  end

  task automatic drive(input bit m, input bit stb, input bit cyc, input bit we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    if (!m) begin
      a_if.stb = stb; a_if.cyc = cyc; a_if.we = we; a_if.sel = sel; a_if.adr = adr;
      a_if.wdat = dat;
    end else begin
      b_if.stb = stb; b_if.cyc = cyc; b_if.we = we; b_if.sel = sel; b_if.adr = adr;
      b_if.wdat = dat;
    end
  endtask

  // Apply the effect of one hitting access to the model; returns the data an ack should carry.
  function automatic logic [31:0] model_access(input bit we, input logic [3:0] sel,
                                               input logic [31:0] adr, input logic [31:0] dat);
    logic [7:0] w;
    w = adr[9:2];
    if (!we) return model_mem[w];
    for (int i = 0; i < 4; i++) if (sel[i]) model_mem[w][8*i +: 8] = dat[8*i +: 8];
    return 32'h0;
  endfunction

  // Call at posedge+#1; returns at posedge+#1 with the port idle. lat = cycles to ack.
  task automatic wb_xfer(input bit m, input bit we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input bit hit, input bit chk_csb, output int lat);
    int start;
    bit got;
    bit saw_csb;
    lat = -1;
    got = 1'b0;
    saw_csb = 1'b0;
    if (hit) begin
      if (!m) exp_a_q.push_back(model_access(we, sel, adr, dat));
      else    exp_b_q.push_back(model_access(we, sel, adr, dat));
    end
    drive(m, 1'b1, 1'b1, we, sel, adr, dat);
    start = cyc_cnt;
    if (hit) begin
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (m ? b_if.ack : a_if.ack) begin
          got = 1'b1;
          lat = cyc_cnt - start;
        end
      end
      check(m ? "b_ack_timeout" : "a_ack_timeout", {31'b0, got}, 32'h1);
    end else begin
      repeat (6) begin
        @(negedge clk);
        if (!sram_csb0) saw_csb = 1'b1;
      end
      if (chk_csb) check("miss_csb", {31'b0, saw_csb}, 32'h0);
    end
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic rand_master(input bit m, input int n);
    int lat;
    int op;
    logic [7:0] word;
    logic [31:0] adr;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      word = 8'($urandom_range(0, 127)) | (m ? 8'h80 : 8'h00);
      adr  = Base | {22'b0, word, 2'b00};
      op   = $urandom_range(0, 7);
      if (op == 0) wb_xfer(m, 1'b1, 4'hF, adr + 32'h400, $urandom, 1'b0, 1'b0, lat);
      else wb_xfer(m, op < 4, (op < 4) ? 4'($urandom_range(1, 15)) : 4'hF, adr, $urandom,
                   1'b1, 1'b0, lat);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, t0, ra, rb;
    bit   last, who;
    bit   exp_who[$];
    logic [31:0] v;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      sram_mem[i]  = v;
      model_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    check("rst_csb0", {31'b0, sram_csb0}, 32'h1);
    check("rst_web0", {31'b0, sram_web0}, 32'h1);
    check("rst_wmask_addr", {20'b0, sram_wmask0, sram_addr0}, 32'h0);
    check("rst_din0", sram_din0, 32'h0);
    check("rst_acks", {30'b0, a_if.ack, b_if.ack}, 32'h0);
    check("rst_rdata", a_if.rdat | b_if.rdat, 32'h0);
    rst_n = 1'b1;

    // Both masters request continuously straight out of reset.
    @(posedge clk); #1;
    t0 = cyc_cnt;
    log_en = 1'b1;
    fork
      for (int i = 0; i < 4; i++) wb_xfer(1'b0, 1'b0, 4'hF, Base + 32'(4 * (40 + i)), 32'h0,
                                          1'b1, 1'b0, lat);
      for (int i = 0; i < 2; i++) wb_xfer(1'b1, 1'b0, 4'hF, Base + 32'(4 * (140 + i)), 32'h0,
                                          1'b1, 1'b0, lat);
    join
    log_en = 1'b0;
    ra = 4; rb = 2; last = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef WB_SRAM_ARB_RR_EN
      who = (ra > 0 && rb > 0) ? ~last : (ra == 0);
`else
      who = (ra == 0);
`endif
      last = who;
      if (who) rb--; else ra--;
      exp_who.push_back(who);
    end
    check("sim_ack_count", 32'(ack_cyc_q.size()), 32'd6);
    for (int k = 0; k < 6 && k < ack_cyc_q.size(); k++) begin
      check("sim_grant_order", {31'b0, ack_who_q[k]}, {31'b0, exp_who[k]});
      check("sim_ack_cycle", 32'(ack_cyc_q[k] - t0), 32'(2 + 3 * k));
    end

    // Single read with cycle-exact control checks.
    sram_mem[5] = 32'hDEAD_BEEF;
    model_mem[5] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    exp_a_q.push_back(model_access(1'b0, 4'hF, 32'h3000_0014, 32'h0));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0014, 32'h0);
    @(negedge clk);
    check("rd_csb_idle", {31'b0, sram_csb0}, 32'h1);
    @(negedge clk);
    check("rd_csb_cmd", {31'b0, sram_csb0}, 32'h0);
    check("rd_addr_cmd", {24'b0, sram_addr0}, 32'd5);
    check("rd_web_cmd", {31'b0, sram_web0}, 32'h1);
    @(negedge clk);
    check("rd_ack_resp", {30'b0, a_if.ack, b_if.ack}, 32'h2);
    check("rd_csb_resp", {31'b0, sram_csb0}, 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Byte-lane write from B, read back by A.
    sram_mem[2] = 32'hFFFF_FFFF;
    model_mem[2] = 32'hFFFF_FFFF;
    wb_xfer(1'b1, 1'b1, 4'b0010, 32'h3000_0008, 32'h1122_3344, 1'b1, 1'b0, lat);
    check("byte_wr_latency", 32'(lat), 32'd2);
    check("byte_wr_mem", sram_mem[2], 32'hFFFF_33FF);
    wb_xfer(1'b0, 1'b0, 4'hF, 32'h3000_0008, 32'h0, 1'b1, 1'b0, lat);

    // Address outside the window is ignored.
    wb_xfer(1'b0, 1'b0, 4'hF, 32'h3000_0400, 32'h0, 1'b0, 1'b1, lat);

    // B aborts a write by dropping cyc in CMD; the write still lands.
    v = model_access(1'b1, 4'hF, Base + 32'd40, 32'hA5A5_5A5A);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, Base + 32'd40, 32'hA5A5_5A5A);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("abort_no_ack", {31'b0, b_if.ack}, 32'h0);
    @(posedge clk); #1;
    check("abort_mem", sram_mem[10], 32'hA5A5_5A5A);
    wb_xfer(1'b0, 1'b0, 4'hF, Base + 32'd40, 32'h0, 1'b1, 1'b0, lat);

    // Reset during CMD of a write: controls return to reset values at once, write is lost.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, Base + 32'd80, 32'h1234_5678);
    @(posedge clk); #2;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("rstmid_csb0", {31'b0, sram_csb0}, 32'h1);
    check("rstmid_acks", {30'b0, a_if.ack, b_if.ack}, 32'h0);
    check("rstmid_din0", sram_din0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_xfer(1'b0, 1'b0, 4'hF, Base + 32'd80, 32'h0, 1'b1, 1'b0, lat);
    check("rstmid_latency", 32'(lat), 32'd2);

    // Randomized traffic; each master owns half the words so its model stays self-contained.
    fork
      rand_master(1'b0, 40);
      rand_master(1'b1, 40);
    join
    repeat (4) @(posedge clk);
    check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
